// File: rtl/bf_program_loader_pkg.sv
// Shared types and constants for the Brainfuck program loader: opcodes,
// error codes, FSM states and the character-decoder result record.
package bf_program_loader_pkg;

    localparam int          DEF_INSTR_W   = 3;
    localparam int          DEF_ADDR_W    = 8;
    localparam int          DEF_DEPTH_W   = 4;
    localparam logic [7:0]  DEF_TERM_CHAR = 8'h00;

    localparam logic [2:0] OP_HALT     = 3'b000;
    localparam logic [2:0] OP_TAPE_INC = 3'b010;
    localparam logic [2:0] OP_TAPE_DEC = 3'b011;
    localparam logic [2:0] OP_PTR_INC  = 3'b100;
    localparam logic [2:0] OP_PTR_DEC  = 3'b101;
    localparam logic [2:0] OP_JMP_FWD  = 3'b110;
    localparam logic [2:0] OP_JMP_BCK  = 3'b111;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_OVERFLOW   = 2'b01,
        ERR_UNBALANCED = 2'b10,
        ERR_DEPTH      = 2'b11
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic       is_op;
        logic       is_open;
        logic       is_close;
        logic       is_term;
        logic [2:0] opcode;
    } dec_t;

endpackage

// File: rtl/bf_char_decoder.sv
// Combinational classifier: maps one ASCII byte to opcode / bracket /
// terminator flags. Anything unrecognised is a comment (all flags clear).
module bf_char_decoder
    import bf_program_loader_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = DEF_TERM_CHAR
) (
    input  logic [7:0] i_byte,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_byte)
            8'h2B: begin o_dec.is_op = 1'b1; o_dec.opcode = OP_TAPE_INC; end
            8'h2D: begin o_dec.is_op = 1'b1; o_dec.opcode = OP_TAPE_DEC; end
            8'h3E: begin o_dec.is_op = 1'b1; o_dec.opcode = OP_PTR_INC;  end
            8'h3C: begin o_dec.is_op = 1'b1; o_dec.opcode = OP_PTR_DEC;  end
            8'h5B: begin
                o_dec.is_op   = 1'b1;
                o_dec.is_open = 1'b1;
                o_dec.opcode  = OP_JMP_FWD;
            end
            8'h5D: begin
                o_dec.is_op    = 1'b1;
                o_dec.is_close = 1'b1;
                o_dec.opcode   = OP_JMP_BCK;
            end
            default: ;
        endcase
        // The terminator wins even if it was configured to an opcode character.
        if (i_byte == TERM_CHAR) begin
            o_dec         = '0;
            o_dec.is_term = 1'b1;
        end
    end

endmodule

// File: rtl/bf_program_loader.sv
// Streams ASCII Brainfuck into program memory as 3-bit opcodes, checks
// brackets, depth and length, pads with HALT and then releases the core.
module bf_program_loader
    import bf_program_loader_pkg::*;
#(
    parameter int         INSTR_W   = DEF_INSTR_W,
    parameter int         ADDR_W    = DEF_ADDR_W,
    parameter int         DEPTH_W   = DEF_DEPTH_W,
    parameter logic [7:0] TERM_CHAR = DEF_TERM_CHAR
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_byte_valid,
    input  logic [7:0]         i_byte,
    output logic               o_byte_ready,
    output logic               o_prgmem_we,
    output logic [ADDR_W-1:0]  o_prgmem_addr,
    output logic [INSTR_W-1:0] o_prgmem_data,
    output logic               o_core_run,
    output logic               o_done,
    output logic               o_error,
    output logic [1:0]         o_err_code,
    output logic [ADDR_W:0]    o_prog_len
);

    localparam logic [ADDR_W:0]    CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]    LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [DEPTH_W-1:0] MAX_DEPTH = {DEPTH_W{1'b1}};

    state_t               state_q, state_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0]   data_q, data_d;
    logic                 run_q, run_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    err_code_t            err_code_q, err_code_d;
    logic [ADDR_W:0]      prog_len_q, prog_len_d;

    dec_t                 dec;
    logic                 byte_ready;
    logic                 accept;

    bf_char_decoder #(
        .TERM_CHAR (TERM_CHAR)
    ) u_decoder (
        .i_byte (i_byte),
        .o_dec  (dec)
    );

    // i_start pre-empts any handshake in the same cycle.
    assign byte_ready = (state_q == ST_LOAD) && !i_start;
    assign accept     = i_byte_valid && byte_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        depth_d    = depth_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        run_d      = run_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        prog_len_d = prog_len_q;

        if (i_start) begin
            state_d    = ST_LOAD;
            count_d    = '0;
            depth_d    = '0;
            run_d      = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            prog_len_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept && dec.is_term) begin
                        if (depth_q != '0) begin
                            state_d    = ST_ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_UNBALANCED;
                            run_d      = 1'b0;
                        end else begin
                            prog_len_d = count_q;
                            if (count_q == CAPACITY) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                run_d   = 1'b1;
                            end else begin
                                state_d = ST_PAD;
                            end
                        end
                    end else if (accept && dec.is_op) begin
                        if (count_q == CAPACITY) begin
                            state_d    = ST_ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_OVERFLOW;
                            run_d      = 1'b0;
                        end else if (dec.is_open && depth_q == MAX_DEPTH) begin
                            state_d    = ST_ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_DEPTH;
                            run_d      = 1'b0;
                        end else if (dec.is_close && depth_q == '0) begin
                            state_d    = ST_ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_UNBALANCED;
                            run_d      = 1'b0;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = count_q[ADDR_W-1:0];
                            data_d  = INSTR_W'(dec.opcode);
                            count_d = count_q + (ADDR_W+1)'(1);
                            if (dec.is_open) begin
                                depth_d = depth_q + DEPTH_W'(1);
                            end else if (dec.is_close) begin
                                depth_d = depth_q - DEPTH_W'(1);
                            end
                        end
                    end
                end
                // One HALT per cycle from the first unused slot to the top of memory.
                ST_PAD: begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    data_d  = INSTR_W'(OP_HALT);
                    count_d = count_q + (ADDR_W+1)'(1);
                    if (count_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        run_d   = 1'b1;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            depth_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            depth_q    <= depth_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            run_q      <= run_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            prog_len_q <= prog_len_d;
        end
    end

    // A restart pulse holds the core immediately, not one cycle later.
    assign o_core_run    = run_q && !i_start;
    assign o_byte_ready  = byte_ready;
    assign o_prgmem_we   = we_q;
    assign o_prgmem_addr = addr_q;
    assign o_prgmem_data = data_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_err_code    = err_code_q;
    assign o_prog_len    = prog_len_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed + randomized bench for bf_program_loader against a queue-based
// model of the loader's outcome (write list, final status, length).
module tb_bf_program_loader;

    logic       i_clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_byte_valid = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       o_byte_ready;
    logic       o_prgmem_we;
    logic [7:0] o_prgmem_addr;
    logic [2:0] o_prgmem_data;
    logic       o_core_run;
    logic       o_done;
    logic       o_error;
    logic [1:0] o_err_code;
    logic [8:0] o_prog_len;

    int checks = 0;
    int failures = 0;
    bit gap_en = 1'b0;

    logic [7:0]  prog_q[$];
    logic [10:0] wr_q[$];
    logic [10:0] exp_wr[$];
    int          n_used;
    bit          exp_done;
    logic [1:0]  exp_code;
    int          exp_len;

    bf_program_loader dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_byte_valid  (i_byte_valid),
        .i_byte        (i_byte),
        .o_byte_ready  (o_byte_ready),
        .o_prgmem_we   (o_prgmem_we),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_core_run    (o_core_run),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_err_code    (o_err_code),
        .o_prog_len    (o_prog_len)
    );

    always #5 i_clock = ~i_clock;

    always @(negedge i_clock)
        if (o_prgmem_we === 1'b1) wr_q.push_back({o_prgmem_addr, o_prgmem_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int op_of(input logic [7:0] b);
        case (b)
            "+": return 2;
            "-": return 3;
            ">": return 4;
            "<": return 5;
            "[": return 6;
            "]": return 7;
            default: return -1;
        endcase
    endfunction

    // Outcome of loading prog_q: which writes happen, how it ends, bytes consumed.
    task automatic model();
        int depth = 0;
        int len = 0;
        int op;
        exp_wr.delete();
        exp_done = 0;
        exp_code = 2'b00;
        exp_len = 0;
        n_used = prog_q.size();
        for (int i = 0; i < prog_q.size(); i++) begin
            if (prog_q[i] == 8'h00) begin
                n_used = i + 1;
                if (depth != 0) exp_code = 2'b10;
                else begin
                    for (int a = len; a < 256; a++) exp_wr.push_back({a[7:0], 3'b000});
                    exp_done = 1;
                    exp_len = len;
                end
                break;
            end
            op = op_of(prog_q[i]);
            if (op < 0) continue;
            if (len == 256) begin exp_code = 2'b01; n_used = i + 1; break; end
            if (op == 6 && depth == 15) begin exp_code = 2'b11; n_used = i + 1; break; end
            if (op == 7 && depth == 0) begin exp_code = 2'b10; n_used = i + 1; break; end
            exp_wr.push_back({len[7:0], op[2:0]});
            len++;
            if (op == 6) depth++;
            if (op == 7) depth--;
        end
    endtask

    task automatic set_prog(input string s);
        prog_q.delete();
        for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        bit ok;
        gap = gap_en ? int'($urandom_range(0, 4)) : 0;
        repeat (gap) begin @(negedge i_clock); i_byte_valid = 1'b0; end
        @(negedge i_clock);
        i_byte_valid = 1'b1;
        i_byte = b;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (o_byte_ready === 1'b1) begin ok = 1; break; end
            @(negedge i_clock);
        end
        if (ok) @(posedge i_clock);
        check("handshake", 32'(ok), 32'd1);
    endtask

    // Start pulse offered together with a '+' byte, which must not be taken.
    task automatic do_start();
        @(negedge i_clock);
        i_start = 1'b1;
        i_byte_valid = 1'b1;
        i_byte = "+";
        #1;
        check("ready_during_start", 32'(o_byte_ready), 32'd0);
        check("run_during_start", 32'(o_core_run), 32'd0);
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        wr_q.delete();
        check("start_done", 32'(o_done), 32'd0);
        check("start_error", 32'(o_error), 32'd0);
        check("start_we", 32'(o_prgmem_we), 32'd0);
        check("start_len", 32'(o_prog_len), 32'd0);
    endtask

    task automatic run_prog(input string tag);
        bit ok;
        int bad;
        model();
        do_start();
        for (int i = 0; i < n_used; i++) send_byte(prog_q[i]);
        @(negedge i_clock);
        i_byte_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            if (o_done === 1'b1 || o_error === 1'b1) begin ok = 1; break; end
            @(negedge i_clock);
        end
        check({tag, "_finish"}, 32'(ok), 32'd1);
        repeat (3) @(negedge i_clock);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            if (wr_q[i] !== exp_wr[i]) bad++;
        check({tag, "_write_mismatches"}, 32'(bad), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'(exp_done));
        check({tag, "_error"}, 32'(o_error), 32'(!exp_done));
        check({tag, "_core_run"}, 32'(o_core_run), 32'(exp_done));
        check({tag, "_err_code"}, 32'(o_err_code), 32'(exp_code));
        if (exp_done) check({tag, "_prog_len"}, 32'(o_prog_len), 32'(exp_len));
    endtask

    task automatic rand_prog(input bit balanced);
        string alpha = "+-<>[]ab \n.";
        int depth = 0;
        int n;
        logic [7:0] c;
        prog_q.delete();
        n = int'($urandom_range(0, 40));
        for (int i = 0; i < n; i++) begin
            c = alpha[$urandom_range(0, alpha.len() - 1)];
            if (balanced && c == "[" && depth >= 6) c = "+";
            if (balanced && c == "]" && depth == 0) c = "-";
            if (c == "[") depth++;
            if (c == "]" && depth > 0) depth--;
            prog_q.push_back(c);
        end
        if (balanced) repeat (depth) prog_q.push_back("]");
        prog_q.push_back(8'h00);
    endtask

    initial begin
        repeat (2) @(negedge i_clock);
        check("rst_ready", 32'(o_byte_ready), 32'd0);
        check("rst_we", 32'(o_prgmem_we), 32'd0);
        check("rst_run", 32'(o_core_run), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_code", 32'(o_err_code), 32'd0);
        check("rst_len", 32'(o_prog_len), 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clock);
        i_byte_valid = 1'b1;
        #1;
        check("idle_ready", 32'(o_byte_ready), 32'd0);
        i_byte_valid = 1'b0;

        set_prog("+[->+<]"); prog_q.push_back(8'h00);
        run_prog("basic");
        set_prog("a+ b\n."); prog_q.push_back(8'h00);
        run_prog("comments");
        set_prog("]");
        run_prog("close_first");
        set_prog("[["); prog_q.push_back(8'h00);
        run_prog("open_unterm");
        set_prog("[[[[[[[[[[[[[[[[");
        run_prog("depth16");
        prog_q.delete();
        prog_q.push_back(8'h00);
        run_prog("empty");
        prog_q.delete();
        repeat (256) prog_q.push_back("+");
        prog_q.push_back(8'h00);
        run_prog("full256");
        prog_q.delete();
        repeat (257) prog_q.push_back("+");
        prog_q.push_back(8'h00);
        run_prog("over257");

        gap_en = 1'b1;
        // Abandon a partial load, then reload from address 0.
        do_start();
        send_byte("-");
        send_byte(">");
        send_byte("[");
        set_prog("<>+"); prog_q.push_back(8'h00);
        run_prog("restart");

        set_prog("+"); prog_q.push_back(8'h00);
        do_start();
        send_byte("+");
        send_byte(8'h00);
        @(negedge i_clock);
        i_byte_valid = 1'b0;
        repeat (20) @(negedge i_clock);
        check("pad_active_we", 32'(o_prgmem_we), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("midpad_rst_we", 32'(o_prgmem_we), 32'd0);
        check("midpad_rst_addr", 32'(o_prgmem_addr), 32'd0);
        check("midpad_rst_data", 32'(o_prgmem_data), 32'd0);
        check("midpad_rst_run", 32'(o_core_run), 32'd0);
        check("midpad_rst_done", 32'(o_done), 32'd0);
        check("midpad_rst_len", 32'(o_prog_len), 32'd0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        i_byte_valid = 1'b1;
        @(negedge i_clock);
        check("post_rst_ready", 32'(o_byte_ready), 32'd0);
        check("post_rst_run", 32'(o_core_run), 32'd0);
        i_byte_valid = 1'b0;

        for (int t = 0; t < 8; t++) begin
            rand_prog(t < 5);
            run_prog($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
